decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- RV32I decode/issue stage sitting directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register file read selects.
- Captures the returned operands plus the decoded fields and immediate into an ID/EX output register.
- Holds issue while a source register has a write still pending, tracked by a 32-entry scoreboard that writeback clears.

Parameters:
- XLEN, 32, datapath and immediate width.
- NREGS, 32, architectural registers; scoreboard width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- reg_1_select  out  5  register file port 1 select = in_instr[19:15].
- reg_2_select  out  5  register file port 2 select = in_instr[24:20].
- reg_1  in  32  register file port 1 data (combinational).
- reg_2  in  32  register file port 2 data (combinational).
- wb_valid  in  1  writeback commits a result this cycle.
- wb_rd  in  5  writeback destination.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  execute consumes the ID/EX contents.
- out_pc  out  32  captured pc.
- out_rs1_val  out  32  captured reg_1.
- out_rs2_val  out  32  captured reg_2.
- out_imm  out  32  sign-extended immediate.
- out_rd  out  5  destination; 0 if the instruction does not write.
- out_opcode  out  7  opcode.
- out_funct3  out  3  funct3.
- out_funct7b5  out  1  instr[30].
- out_illegal  out  1  opcode not in the supported set.

Behaviour:
- Reset (async, reset_n=0): out_valid=0; all out_* = 0; scoreboard=0. The selects stay combinational.
- Supported opcodes:
  - LUI 0110111, AUIPC 0010111: U-type, write rd.
  - JAL 1101111: J-type, writes rd.
  - JALR 1100111: I-type, reads rs1, writes rd.
  - BRANCH 1100011: B-type, reads rs1 and rs2.
  - LOAD 0000011: I-type, reads rs1, writes rd.
  - STORE 0100011: S-type, reads rs1 and rs2.
  - OP-IMM 0010011: I-type, reads rs1, writes rd.
  - OP 0110011: no immediate (imm=0), reads rs1 and rs2, writes rd.
  - Any other opcode: out_illegal=1, no reads, no writes, imm=0.
- Immediates are sign-extended from instr[31]; B and J immediates have bit0=0; U immediate = {instr[31:12],12'b0}.
- pending(r) = sb[r] && !(wb_valid && wb_rd==r). The register file commits at negedge, so a same-cycle writeback is readable by the posedge.
- hazard = (uses_rs1 && rs1!=0 && pending(rs1)) || (uses_rs2 && rs2!=0 && pending(rs2)) || (writes_rd && rd!=0 && pending(rd)). The rd term blocks WAW.
- in_ready = !hazard && (!out_valid || out_ready). This is combinational, with no dependency on in_valid.
- Accept (in_valid && in_ready) at posedge:
  - load the ID/EX register;
  - out_valid←1;
  - out_rs1_val←reg_1, out_rs2_val←reg_2.
- If out_valid && out_ready && !accept: out_valid←0. The data fields hold their last value.
- Output register states are EMPTY (out_valid=0) and FULL. EMPTY→FULL on accept. FULL→FULL on consume+accept or on hold. FULL→EMPTY on consume without accept.
- Scoreboard per posedge, in this order:
  - clear sb[wb_rd] if wb_valid;
  - then set sb[rd] if accept && writes_rd && rd!=0.
  - Set wins on the same index.
  - sb[0] is always 0.
- Latency: operand read to out_valid is 1 cycle. Back-to-back issue gives 1 instr/cycle when there is no hazard and out_ready=1.
- wb_valid with a clear bit, or with wb_rd=0: no effect.
- Reset mid-operation: the in-flight ID/EX contents and the scoreboard are discarded immediately.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams;
  - the imm-format enum {IMM_I,IMM_S,IMM_B,IMM_U,IMM_J,IMM_NONE};
  - the XLEN constant.
- Sub-module rv32i_decoder: purely combinational. It produces uses_rs1, uses_rs2, writes_rd, imm, and illegal from the instruction. The scoreboard and the ID/EX register stay in the top module.

Test Plan:
- Reset, regfile x1=0x10, x2=0x20; issue `add x3,x1,x2` (0x002081B3) with out_ready=1 → next cycle out_valid=1, rs1_val=0x10, rs2_val=0x20, out_rd=3, sb[3]=1.
- Issue `addi x4,x3,-1` (0xFFF18213) while sb[3]=1 and wb_valid=0 → in_ready=0 and held. Cycle with wb_valid=1, wb_rd=3 → accepted that cycle, out_imm=0xFFFFFFFF.
- Hold out_ready=0 with out_valid=1 for 3 cycles → in_ready=0 and out_* stable. Raise out_ready together with a new instruction → swap in 1 cycle, no bubble.
- `sw x5,8(x6)` (0x00532423) → out_imm=8, out_rd=0, sb unchanged. `beq x0,x0,-4` (0xFE000EE3) → out_imm=0xFFFFFFFC. `jal x1,2048` (0x001000EF) → out_imm=0x00000800.
- Same-cycle writeback clear of x7 and accept of `lui x7,0x12345` (0x123453B7) → sb[7]=1 afterward and out_imm=0x12345000. Opcode 0x7F → out_illegal=1, no sb set.
- Assert reset_n low asynchronously mid-cycle while FULL with sb nonzero → out_valid and sb go to 0 immediately, without waiting for an edge. After release, first accept proceeds normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, immediate formats and
// the ID/EX output register states.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_e;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I field decoder: register usage, immediate,
// and legality of the opcode.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0]     instr,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opc;
    imm_fmt_e   fmt;

    assign opc = instr[6:0];

    always_comb begin
        fmt       = IMM_NONE;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        unique case (1'b1)
            (opc == OPC_LUI) || (opc == OPC_AUIPC): begin
                fmt       = IMM_U;
                writes_rd = 1'b1;
            end
            (opc == OPC_JAL): begin
                fmt       = IMM_J;
                writes_rd = 1'b1;
            end
            (opc == OPC_JALR) || (opc == OPC_LOAD) || (opc == OPC_OPIMM): begin
                fmt       = IMM_I;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            (opc == OPC_BRANCH): begin
                fmt      = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opc == OPC_STORE): begin
                fmt      = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opc == OPC_OP): begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue: drives regfile selects, blocks on scoreboard
// hazards and captures operands plus decoded fields into ID/EX.
module decode_issue_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      reg_1_select,
    output logic [4:0]      reg_2_select,
    input  logic [XLEN-1:0] reg_1,
    input  logic [XLEN-1:0] reg_2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    import rv32i_pkg::*;

    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2, writes_rd, dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            hazard, accept;

    out_state_e      state_q, state_d;
    logic [NREGS-1:0] sb_q, sb_d;

    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] rs1v_q, rs1v_d;
    logic [XLEN-1:0] rs2v_q, rs2v_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [6:0]      opc_q, opc_d;
    logic [2:0]      f3_q, f3_d;
    logic            f7b5_q, f7b5_d;
    logic            ill_q, ill_d;

    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign rd  = in_instr[11:7];

    assign reg_1_select = rs1;
    assign reg_2_select = rs2;

    rv32i_decoder u_dec (
        .instr     (in_instr),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .illegal   (dec_illegal),
        .imm       (dec_imm)
    );

    // Regfile writes at negedge, so a same-cycle writeback already
    // resolves the dependency.
    function automatic logic pending(input logic [4:0] r);
        return sb_q[r] && !(wb_valid && (wb_rd == r));
    endfunction

    always_comb begin
        hazard = (uses_rs1 && (rs1 != 5'd0) && pending(rs1))
              || (uses_rs2 && (rs2 != 5'd0) && pending(rs2))
              || (writes_rd && (rd != 5'd0) && pending(rd));
    end

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
    end

    always_comb begin
        sb_d = sb_q;
        if (wb_valid) sb_d[wb_rd] = 1'b0;
        if (accept && writes_rd && (rd != 5'd0)) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        pc_d   = pc_q;
        rs1v_d = rs1v_q;
        rs2v_d = rs2v_q;
        imm_d  = imm_q;
        rd_d   = rd_q;
        opc_d  = opc_q;
        f3_d   = f3_q;
        f7b5_d = f7b5_q;
        ill_d  = ill_q;
        if (accept) begin
            pc_d   = in_pc;
            rs1v_d = reg_1;
            rs2v_d = reg_2;
            imm_d  = dec_imm;
            rd_d   = writes_rd ? rd : 5'd0;
            opc_d  = in_instr[6:0];
            f3_d   = in_instr[14:12];
            f7b5_d = in_instr[30];
            ill_d  = dec_illegal;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb_q   <= '0;
            pc_q   <= '0;
            rs1v_q <= '0;
            rs2v_q <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            opc_q  <= '0;
            f3_q   <= '0;
            f7b5_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            pc_q   <= pc_d;
            rs1v_q <= rs1v_d;
            rs2v_q <= rs2v_d;
            imm_q  <= imm_d;
            rd_q   <= rd_d;
            opc_q  <= opc_d;
            f3_q   <= f3_d;
            f7b5_q <= f7b5_d;
            ill_q  <= ill_d;
        end
    end

    assign out_pc       = pc_q;
    assign out_rs1_val  = rs1v_q;
    assign out_rs2_val  = rs2v_q;
    assign out_imm      = imm_q;
    assign out_rd       = rd_q;
    assign out_opcode   = opc_q;
    assign out_funct3   = f3_q;
    assign out_funct7b5 = f7b5_q;
    assign out_illegal  = ill_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: expected ID/EX contents
// are queued on accept and compared while the register holds them.
module tb_decode_issue_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  reg_1_select, reg_2_select;
    logic [31:0] reg_1, reg_2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    // Regfile model: xN holds N*16, x0 reads zero.
    function automatic logic [31:0] rf(input logic [4:0] r);
        return {23'b0, r, 4'b0};
    endfunction

    assign reg_1 = rf(reg_1_select);
    assign reg_2 = rf(reg_2_select);

    decode_issue_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .reg_1_select (reg_1_select),
        .reg_2_select (reg_2_select),
        .reg_1        (reg_1),
        .reg_2        (reg_2),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_illegal  (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_rs1_val", out_rs1_val, exp_q[0].rs1);
            chk("out_rs2_val", out_rs2_val, exp_q[0].rs2);
            chk("out_imm", out_imm, exp_q[0].imm);
            chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
            chk("out_opcode", 32'(out_opcode), 32'(exp_q[0].opc));
            chk("out_funct3", 32'(out_funct3), 32'(exp_q[0].f3));
            chk("out_funct7b5", 32'(out_funct7b5), 32'(exp_q[0].f7));
            chk("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy,
                        input logic wbv, input logic [4:0] wbrd,
                        input logic rdy, input logic [31:0] imm,
                        input logic [4:0] rd, input logic ill);
        exp_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        wb_valid  = wbv;
        wb_rd     = wbrd;
        #2;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("reg_1_select", 32'(reg_1_select), 32'(ins[19:15]));
        chk("reg_2_select", 32'(reg_2_select), 32'(ins[24:20]));
        if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
        if (v && rdy) begin
            e.pc  = pc;
            e.rs1 = rf(ins[19:15]);
            e.rs2 = rf(ins[24:20]);
            e.imm = imm;
            e.rd  = rd;
            e.opc = ins[6:0];
            e.f3  = ins[14:12];
            e.f7  = ins[30];
            e.ill = ill;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        check_out();
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_ADDI4 = 32'hFFF18213;
    localparam logic [31:0] I_SW    = 32'h00532423;
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
    localparam logic [31:0] I_JAL   = 32'h001000EF;
    localparam logic [31:0] I_ADDI7 = 32'h00500393;
    localparam logic [31:0] I_LUI7  = 32'h123453B7;
    localparam logic [31:0] I_ADDI8 = 32'h00038413;
    localparam logic [31:0] I_ILL   = 32'h00000FFF;
    localparam logic [31:0] I_ADDI9 = 32'h000F8493;
    localparam logic [31:0] I_ADDI5 = 32'h00120293;
    localparam logic [31:0] I_LUI5  = 32'h000012B7;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        step(1, I_ADD,   32'h100, 1, 0, 0, 1, 32'h0, 3, 0);
        step(1, I_ADDI4, 32'h104, 1, 0, 0, 0, 32'h0, 0, 0);
        step(1, I_ADDI4, 32'h104, 1, 1, 3, 1, 32'hFFFFFFFF, 4, 0);
        repeat (3) step(1, I_SW, 32'h108, 0, 0, 0, 0, 32'h0, 0, 0);
        step(1, I_SW,    32'h108, 1, 0, 0, 1, 32'h8, 0, 0);
        step(1, I_BEQ,   32'h10C, 1, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
        step(1, I_JAL,   32'h110, 1, 0, 0, 1, 32'h800, 1, 0);
        step(1, I_ADDI7, 32'h114, 1, 0, 0, 1, 32'h5, 7, 0);
        step(1, I_LUI7,  32'h118, 1, 1, 7, 1, 32'h12345000, 7, 0);
        step(1, I_ADDI8, 32'h11C, 1, 0, 0, 0, 32'h0, 0, 0);
        step(1, I_ADDI8, 32'h11C, 1, 1, 7, 1, 32'h0, 8, 0);
        step(1, I_ILL,   32'h120, 1, 0, 0, 1, 32'h0, 0, 1);
        step(1, I_ADDI9, 32'h124, 1, 1, 0, 1, 32'h0, 9, 0);

        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_pc", out_pc, 32'd0);
        chk("async_rd", 32'(out_rd), 32'd0);
        chk("async_imm", out_imm, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        step(1, I_ADDI5, 32'h200, 1, 0, 0, 1, 32'h1, 5, 0);
        step(1, I_LUI5,  32'h204, 1, 0, 0, 0, 32'h0, 0, 0);
        step(1, I_LUI5,  32'h204, 1, 1, 5, 1, 32'h1000, 5, 0);
        step(0, 32'h0,   32'h0,   1, 0, 0, 1, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
